pp_loader: RTL and testbench

PP_LOADER -- requirements
Module: pp_loader

---
 rtl/pp_loader_if.sv | 31 +++
 rtl/pp_loader.sv | 199 +++++++++++++++++++
 tb/tb_pp_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pp_loader_if.sv
// Byte-stream loader bus: inbound byte handshake, memory write port, status.
// master: byte source / memory side (testbench or host glue).
// slave : the loader itself (pp_loader).
interface pp_loader_if #(
  parameter int ADDR_W = 32
);
  // inbound byte stream (valid/ready)
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  // memory write port (mem_we/mem_ready)
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  // status toward the core
  logic              core_hold;
  logic              done;
  logic              err;

  modport master (
    output rx_valid, rx_data, mem_ready,
    input  rx_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_hold, done, err
  );

  modport slave (
    input  rx_valid, rx_data, mem_ready,
    output rx_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_hold, done, err
  );
endinterface

// File: rtl/pp_loader.sv
// Program loader: parses framed byte stream (hdr, tgt, addr[4], cnt[2], words)
// and writes each 32-bit word to instruction or data memory.
// Latency: last byte of a word -> mem_we one cycle later; write done -> done/err next cycle.
// Backpressure: rx_ready drops only while a write waits for mem_ready.
// Ports: clk, rst (async, active-high); bus (pp_loader_if.slave) carries the
//   rx_* byte handshake, mem_* write port, core_hold, done and err.
// Option: define PP_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module pp_loader #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         ADDR_W   = 32
) (
  input logic         clk,
  input logic         rst,
  pp_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, TGT, ADDR, CNT, DATA, WRITE
`ifdef PP_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t            state_q, state_nxt;
  logic [1:0]        bcnt_q, bcnt_nxt;     // byte position within ADDR/CNT/DATA
  logic [31:0]       shift_q, shift_nxt;   // MSB-first byte assembly
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [15:0]       rem_q, rem_nxt;       // words still to write
  logic [31:0]       wdata_q, wdata_nxt;
  logic              sel_q, sel_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              rdy_q, we_q, hold_q;
`ifdef PP_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_nxt;
`endif

  logic        acc;
  logic [31:0] word;   // assembly register with the current byte appended

  assign acc  = bus.rx_valid & rdy_q;
  assign word = {shift_q[23:0], bus.rx_data};

  always_comb begin
    state_nxt = state_q;
    bcnt_nxt  = bcnt_q;
    shift_nxt = shift_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    wdata_nxt = wdata_q;
    sel_nxt   = sel_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
`ifdef PP_LOADER_CHECKSUM_EN
    csum_nxt  = csum_q;
    // Running XOR covers target byte through last data byte.
    if (acc && state_q != IDLE && state_q != CSUM)
      csum_nxt = (state_q == TGT) ? bus.rx_data : (csum_q ^ bus.rx_data);
`endif
    case (state_q)
      IDLE: begin
        // Non-header bytes are silently dropped.
        if (acc && bus.rx_data == HDR_BYTE) state_nxt = TGT;
      end
      TGT: begin
        if (acc) begin
          bcnt_nxt = 2'd0;
          if (bus.rx_data[7:1] != 7'd0) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            sel_nxt   = bus.rx_data[0];
            state_nxt = ADDR;
          end
        end
      end
      ADDR: begin
        if (acc) begin
          shift_nxt = word;
          bcnt_nxt  = bcnt_q + 2'd1;   // wraps to 0 after the 4th byte
          if (bcnt_q == 2'd3) begin
            if (word[1:0] != 2'd0) begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end else begin
              addr_nxt  = ADDR_W'(word);
              state_nxt = CNT;
            end
          end
        end
      end
      CNT: begin
        if (acc) begin
          shift_nxt = word;
          bcnt_nxt  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd1) begin
            bcnt_nxt = 2'd0;
            if (word[15:0] == 16'd0) begin
`ifdef PP_LOADER_CHECKSUM_EN
              state_nxt = CSUM;
`else
              done_nxt  = 1'b1;
              state_nxt = IDLE;
`endif
            end else begin
              rem_nxt   = word[15:0];
              state_nxt = DATA;
            end
          end
        end
      end
      DATA: begin
        if (acc) begin
          shift_nxt = word;
          bcnt_nxt  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wdata_nxt = word;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        // mem_we is high for the whole of WRITE, so mem_ready alone completes it.
        if (bus.mem_ready) begin
          addr_nxt = addr_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W
          rem_nxt  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef PP_LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            done_nxt  = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
      end
`ifdef PP_LOADER_CHECKSUM_EN
      CSUM: begin
        if (acc) begin
          done_nxt  = (bus.rx_data == csum_q);
          err_nxt   = (bus.rx_data != csum_q);
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= 2'd0;
      shift_q <= 32'd0;
      addr_q  <= '0;
      rem_q   <= 16'd0;
      wdata_q <= 32'd0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
`ifdef PP_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_nxt;
      bcnt_q  <= bcnt_nxt;
      shift_q <= shift_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      wdata_q <= wdata_nxt;
      sel_q   <= sel_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      // Outputs registered from the next state so they are glitch-free.
      rdy_q   <= (state_nxt != WRITE);
      we_q    <= (state_nxt == WRITE);
      // Hold stays up through the done/err pulse cycle even though state is IDLE.
      hold_q  <= (state_nxt != IDLE) | done_nxt | err_nxt;
`ifdef PP_LOADER_CHECKSUM_EN
      csum_q  <= csum_nxt;
`endif
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pp_loader.sv
// Testbench for pp_loader: frames built from the frame format rules, expected
// writes/outcome kept in queues, randomized byte gaps and memory stalls.
module tb_pp_loader;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef PP_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pp_loader_if #(.ADDR_W(32)) bus ();
  pp_loader #(.HDR_BYTE(HDR), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0] fb[$];     // bytes to send
  wr_t        ew[$];     // expected writes, in order
  bit         exp_done, exp_err;
  int         base, nw;  // index of header byte, number of data words

  task automatic build_frame(input int n_garb, input logic [7:0] tgt, input logic [31:0] addr,
                             input int cnt, input logic [31:0] first, input bit bad_csum);
    logic [7:0]  x;
    logic [7:0]  g;
    logic [31:0] w;
    fb.delete(); ew.delete();
    exp_done = 0; exp_err = 0; nw = 0; base = n_garb;
    for (int i = 0; i < n_garb; i++) begin
      g = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
      if (g == HDR) g = 8'h00;
      fb.push_back(g);
    end
    fb.push_back(HDR);
    fb.push_back(tgt);
    if (tgt > 8'd1) begin exp_err = 1; return; end
    for (int i = 3; i >= 0; i--) fb.push_back(addr[8*i +: 8]);
    if (addr[1:0] != 2'd0) begin exp_err = 1; return; end
    fb.push_back(8'(cnt >> 8));
    fb.push_back(8'(cnt));
    nw = cnt;
    for (int k = 0; k < cnt; k++) begin
      w = (k == 0) ? first : $urandom;
      for (int i = 3; i >= 0; i--) fb.push_back(w[8*i +: 8]);
      ew.push_back('{sel: tgt[0], addr: addr + 32'(4 * k), data: w});
    end
    if (CSUM_EN) begin
      x = 8'h00;
      for (int i = base + 1; i < fb.size(); i++) x ^= fb[i];
      fb.push_back(bad_csum ? ~x : x);
      if (bad_csum) begin exp_err = 1; return; end
    end
    exp_done = 1;
  endtask

  // stall >= 0: mem_ready held low for 'stall' cycles of each write; -1: random.
  task automatic run_frame(input string name, input int stall);
    int  idx = 0, got_done = 0, got_err = 0, we_run = 0, cyc = 0, idle_after = 0;
    bit  lat_pend = 0, done_pend = 0;
    wr_t w;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (lat_pend) check({name, ":latency_we"}, bus.mem_we, 1);
`ifndef PP_LOADER_CHECKSUM_EN
      if (done_pend) check({name, ":done_after_write"}, bus.done, 1);
`endif
      lat_pend = 0; done_pend = 0;
      if (bus.done) got_done++;
      if (bus.err)  got_err++;
      if (bus.done || bus.err) begin
        check({name, ":done_err_excl"}, bus.done & bus.err, 0);
        check({name, ":hold_at_end"}, bus.core_hold, 1);
        check({name, ":rdy_at_end"}, bus.rx_ready, 1);
      end
      if (stall >= 0) bus.mem_ready = (we_run >= stall);
      else            bus.mem_ready = ($urandom_range(2) != 0);
      if (bus.mem_we) begin
        check({name, ":rdy_low_in_write"}, bus.rx_ready, 0);
        check({name, ":hold_in_write"}, bus.core_hold, 1);
        we_run++;
        if (bus.mem_ready) begin
          if (stall >= 0) check({name, ":we_hold_cycles"}, we_run, stall + 1);
          we_run = 0;
          if (ew.size() == 0) check({name, ":unexpected_write"}, 1, 0);
          else begin
            w = ew.pop_front();
            check({name, ":wr_sel"},  bus.mem_sel,   w.sel);
            check({name, ":wr_addr"}, bus.mem_addr,  w.addr);
            check({name, ":wr_data"}, bus.mem_wdata, w.data);
            if (ew.size() == 0) done_pend = 1;
          end
        end
      end
      if (idx < fb.size() && $urandom_range(3) != 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = fb[idx];
        if (bus.rx_ready) begin
          if (idx >= base + 8 && idx < base + 8 + 4 * nw && ((idx - base - 8) % 4) == 3)
            lat_pend = 1;
          idx++;
        end
      end else begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
      if (idx == fb.size() && ew.size() == 0 && (got_done + got_err) > 0) idle_after++;
      if (idle_after > 3) break;
    end
    bus.rx_valid = 1'b0;
    check({name, ":bytes_sent"}, idx, fb.size());
    check({name, ":writes_left"}, ew.size(), 0);
    check({name, ":done_count"}, got_done, exp_done);
    check({name, ":err_count"}, got_err, exp_err);
    check({name, ":hold_idle"}, bus.core_hold, 0);
    check({name, ":rdy_idle"}, bus.rx_ready, 1);
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.mem_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_sel", bus.mem_sel, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_hold", bus.core_hold, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", bus.rx_ready, 1);

    build_frame(0, 8'h00, 32'h0040_0000, 1, 32'h2008_0005, 0);
    run_frame("single_word", 0);
    build_frame(0, 8'h01, 32'h1000_0000, 2, $urandom, 0);
    run_frame("stall3", 3);
    build_frame(0, 8'h00, 32'h1000_0002, 1, $urandom, 0);
    run_frame("misaligned", -1);
    build_frame(2, 8'h01, 32'h0000_0100, 1, $urandom, 0);
    run_frame("garbage_first", -1);
    build_frame(0, 8'h04, 32'h0, 1, $urandom, 0);
    run_frame("bad_target", -1);
    build_frame(0, 8'h00, 32'h0000_0040, 0, $urandom, 0);
    run_frame("count_zero", -1);
    build_frame(0, 8'h01, 32'hFFFF_FFF8, 3, $urandom, 0);
    run_frame("addr_wrap", -1);
`ifdef PP_LOADER_CHECKSUM_EN
    build_frame(0, 8'h01, 32'h0000_2000, 2, $urandom, 1);
    run_frame("bad_csum", -1);
    build_frame(0, 8'h01, 32'h0000_2000, 2, $urandom, 0);
    run_frame("good_csum", -1);
`endif

    for (int f = 0; f < 20; f++) begin
      logic [7:0]  t;
      logic [31:0] a;
      t = ($urandom_range(7) == 0) ? (8'h80 | 8'($urandom_range(127))) : 8'($urandom_range(1));
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) a[0] = 1'b1;
      build_frame($urandom_range(3), t, a, $urandom_range(4), $urandom, $urandom_range(3) == 0);
      run_frame("random", -1);
    end

    // Reset while a write is pending
    build_frame(0, 8'h00, 32'h2000_0000, 2, $urandom, 0);
    begin
      int idx = 0;
      int c = 0;
      while (c < 200) begin
        @(negedge clk);
        c++;
        if (bus.mem_we) break;
        bus.mem_ready = 1'b0;
        if (idx < fb.size()) begin
          bus.rx_valid = 1'b1;
          bus.rx_data  = fb[idx];
          if (bus.rx_ready) idx++;
        end
      end
      check("rstw_reach_write", bus.mem_we, 1);
      bus.rx_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rstw_mem_we", bus.mem_we, 0);
      check("rstw_hold", bus.core_hold, 0);
      check("rstw_done", bus.done, 0);
      check("rstw_err", bus.err, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) check("rstw_rdy", bus.rx_ready, 1);
        check("rstw_no_pulse", {bus.done, bus.err, bus.mem_we}, 3'b000);
      end
    end
    build_frame(1, 8'h00, 32'h0000_0800, 2, $urandom, 0);
    run_frame("after_reset", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
